// File: rtl/des_pipe_ctrl_if.sv
// Handshake bundle for des_pipe_ctrl: two request channels, key load port and result stream.
// master = requester/consumer side, slave = controller side.
interface des_pipe_ctrl_if;
    logic        s0_valid;
    logic        s0_ready;
    logic [64:1] s0_data;
    logic        s1_valid;
    logic        s1_ready;
    logic [64:1] s1_data;
    logic        key_valid;
    logic        key_ready;
    logic [55:0] key_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        m_id;

    modport master (
        output s0_valid, s0_data, s1_valid, s1_data, key_valid, key_data, m_ready,
        input  s0_ready, s1_ready, key_ready, m_valid, m_data, m_id
    );

    modport slave (
        input  s0_valid, s0_data, s1_valid, s1_data, key_valid, key_data, m_ready,
        output s0_ready, s1_ready, key_ready, m_valid, m_data, m_id
    );
endinterface

// File: rtl/des_pipe_ctrl.sv
// Sequencer/arbiter for a LAT-stage pipelined DES datapath: round-robin admission of two channels,
// key swap only when drained, credit-guarded result FIFO. Optional counters under DES_CTRL_STATS_EN.
module des_pipe_ctrl #(
    parameter int LAT        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    des_pipe_ctrl_if.slave bus,
    output logic [31:0]    dp_in_l,
    output logic [31:0]    dp_in_r,
    output logic [55:0]    dp_key,
    input  logic [31:0]    dp_out_l,
    input  logic [31:0]    dp_out_r,
    output logic           busy
`ifdef DES_CTRL_STATS_EN
    ,
    output logic [31:0]    blk_cnt0,
    output logic [31:0]    blk_cnt1,
    output logic [31:0]    stall_cnt
`endif
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {NOKEY, RUN, DRAIN, LOAD} state_t;

    state_t        state_q, state_d;
    logic          rr_q, rr_d;
    logic [LAT:0]  tag_vld_q, tag_vld_d;
    logic [LAT:0]  tag_id_q, tag_id_d;
    logic [CW-1:0] infl_q, infl_d;
    logic [CW-1:0] fcnt_q, fcnt_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [31:0]   dp_in_l_q, dp_in_l_d;
    logic [31:0]   dp_in_r_q, dp_in_r_d;
    logic [55:0]   dp_key_q, dp_key_d;
    logic [64:0]   mem_q [FIFO_DEPTH];
    logic [64:0]   mem_d [FIFO_DEPTH];

    logic          admit, gnt0, gnt1, acc, push, pop, m_valid;
    logic [CW:0]   used;
    logic [64:0]   head;

    // Credit counts the FIFO occupancy before this edge, so a pop never frees a slot early.
    always_comb begin
        used  = {1'b0, infl_q} + {1'b0, fcnt_q};
        admit = (state_q == RUN) && !bus.key_valid && (used < DEPTH_C);
        gnt1  = bus.s1_valid && (!bus.s0_valid || rr_q);
        gnt0  = bus.s0_valid && !gnt1;
        acc   = admit && (gnt0 || gnt1);
        push  = tag_vld_q[LAT];
        pop   = (fcnt_q != '0) && bus.m_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NOKEY:   if (bus.key_valid) state_d = LOAD;
            RUN:     if (bus.key_valid) state_d = DRAIN;
            DRAIN:   if (infl_q == '0) state_d = LOAD;
            LOAD:    state_d = RUN;
            default: state_d = NOKEY;
        endcase
    end

    always_comb begin
        rr_d      = rr_q;
        dp_in_l_d = dp_in_l_q;
        dp_in_r_d = dp_in_r_q;
        dp_key_d  = dp_key_q;
        infl_d    = infl_q;
        fcnt_d    = fcnt_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
        // Tag stage 0 lines up with dp_in; stage LAT lines up with dp_out.
        tag_vld_d = {tag_vld_q[LAT-1:0], acc};
        tag_id_d  = {tag_id_q[LAT-1:0], acc && gnt1};

        if (acc) begin
            rr_d      = !gnt1;
            dp_in_l_d = gnt1 ? bus.s1_data[64:33] : bus.s0_data[64:33];
            dp_in_r_d = gnt1 ? bus.s1_data[32:1]  : bus.s0_data[32:1];
        end
        if (state_q == LOAD) dp_key_d = bus.key_data;

        if (acc && !push)      infl_d = infl_q + 1'b1;
        else if (!acc && push) infl_d = infl_q - 1'b1;
        if (push && !pop)      fcnt_d = fcnt_q + 1'b1;
        else if (!push && pop) fcnt_d = fcnt_q - 1'b1;

        if (push) begin
            mem_d[wr_q] = {dp_out_l, dp_out_r, tag_id_q[LAT]};
            wr_d        = (wr_q == LAST_P) ? '0 : wr_q + 1'b1;
        end
        if (pop) rd_d = (rd_q == LAST_P) ? '0 : rd_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= NOKEY;
            rr_q      <= 1'b0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
            infl_q    <= '0;
            fcnt_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            dp_in_l_q <= '0;
            dp_in_r_q <= '0;
            dp_key_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
            infl_q    <= infl_d;
            fcnt_q    <= fcnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            dp_in_l_q <= dp_in_l_d;
            dp_in_r_q <= dp_in_r_d;
            dp_key_q  <= dp_key_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign head          = mem_q[rd_q];
    assign m_valid       = (fcnt_q != '0);
    assign bus.m_valid   = m_valid;
    assign bus.m_data    = m_valid ? head[64:1] : 64'd0;
    assign bus.m_id      = m_valid & head[0];
    assign bus.s0_ready  = admit && gnt0;
    assign bus.s1_ready  = admit && gnt1;
    assign bus.key_ready = (state_q == LOAD);
    assign dp_in_l       = dp_in_l_q;
    assign dp_in_r       = dp_in_r_q;
    assign dp_key        = dp_key_q;
    assign busy          = (infl_q != '0) || m_valid;

`ifdef DES_CTRL_STATS_EN
    logic [31:0] blk_cnt0_q, blk_cnt0_d;
    logic [31:0] blk_cnt1_q, blk_cnt1_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        blk_cnt0_d  = blk_cnt0_q;
        blk_cnt1_d  = blk_cnt1_q;
        stall_cnt_d = stall_cnt_q;
        if (state_q == LOAD) begin
            blk_cnt0_d  = '0;
            blk_cnt1_d  = '0;
            stall_cnt_d = '0;
        end else begin
            if (pop && !head[0]) blk_cnt0_d = blk_cnt0_q + 32'd1;
            if (pop && head[0])  blk_cnt1_d = blk_cnt1_q + 32'd1;
            if ((bus.s0_valid || bus.s1_valid) && !acc) stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt0_q  <= '0;
            blk_cnt1_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            blk_cnt0_q  <= blk_cnt0_d;
            blk_cnt1_q  <= blk_cnt1_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign blk_cnt0  = blk_cnt0_q;
    assign blk_cnt1  = blk_cnt1_q;
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_des_pipe_ctrl.sv
// Directed bench for des_pipe_ctrl with a 16-stage Feistel stand-in for the DES round datapath
// and a scoreboard of expected results built from a loop-form reference of the same rounds.
module tb_des_pipe_ctrl;
    localparam int LAT        = 16;
    localparam int FIFO_DEPTH = 4;
    localparam logic [55:0] K1 = 56'h123456789ABCDE;
    localparam logic [55:0] K2 = 56'hA5A5_0F0F_3C3C_99;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    des_pipe_ctrl_if bus();
    logic [31:0] dp_in_l, dp_in_r, dp_out_l, dp_out_r;
    logic [55:0] dp_key;
    logic        busy;
`ifdef DES_CTRL_STATS_EN
    logic [31:0] blk_cnt0, blk_cnt1, stall_cnt;
`endif

    des_pipe_ctrl #(.LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .dp_in_l  (dp_in_l),
        .dp_in_r  (dp_in_r),
        .dp_key   (dp_key),
        .dp_out_l (dp_out_l),
        .dp_out_r (dp_out_r),
        .busy     (busy)
`ifdef DES_CTRL_STATS_EN
        ,
        .blk_cnt0 (blk_cnt0),
        .blk_cnt1 (blk_cnt1),
        .stall_cnt(stall_cnt)
`endif
    );

    function automatic logic [31:0] rk(input logic [55:0] k, input int rnd);
        logic [55:0] t;
        t = (k << rnd) | (k >> (56 - rnd));
        return t[31:0] ^ t[55:24];
    endfunction

    function automatic logic [31:0] rf(input logic [31:0] r, input logic [31:0] sk);
        return ({r[26:0], r[31:27]} + sk) ^ {sk[15:0], r[31:16]};
    endfunction

    function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [55:0] k);
        logic [31:0] l, r, t;
        l = blk[63:32];
        r = blk[31:0];
        for (int s = 1; s <= LAT; s++) begin
            t = r;
            r = l ^ rf(r, rk(k, s));
            l = t;
        end
        return {l, r};
    endfunction

    // Round datapath: one register per round, key schedule taken live from dp_key.
    logic [31:0] pl [1:LAT];
    logic [31:0] pr [1:LAT];
    always @(posedge clk) begin
        pl[1] <= dp_in_r;
        pr[1] <= dp_in_l ^ rf(dp_in_r, rk(dp_key, 1));
        for (int s = 2; s <= LAT; s++) begin
            pl[s] <= pr[s-1];
            pr[s] <= pl[s-1] ^ rf(pr[s-1], rk(dp_key, s));
        end
    end
    assign dp_out_l = pl[LAT];
    assign dp_out_r = pr[LAT];

    int          total = 0;
    int          bad   = 0;
    int          cyc_n = 0;
    int          seq   = 0;
    logic [55:0] key_cur = '0;
    logic [64:0] exp_q [$];
    int          acc_ch [$];
    int          acc_cyc [$];
    int          pop_cyc [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive valids/ready, score accepts and pops just before the edge.
    task automatic cyc(input logic v0, input logic v1, input logic rdy);
        logic [63:0] d0, d1;
        logic [64:0] e;
        d0 = {32'h0123_4567 + 32'(seq), 32'h89AB_CDEF ^ 32'(seq)};
        d1 = {32'hFEDC_BA98 - 32'(seq), 32'h0F1E_2D3C + 32'(seq * 7)};
        bus.s0_valid = v0;
        bus.s1_valid = v1;
        bus.s0_data  = d0;
        bus.s1_data  = d1;
        bus.m_ready  = rdy;
        #1;
        chk("one_ready", 64'(bus.s0_ready & bus.s1_ready), 64'd0);
        if (bus.s0_ready) begin
            exp_q.push_back({des_ref(d0, key_cur), 1'b0});
            acc_ch.push_back(0);
            acc_cyc.push_back(cyc_n);
            seq++;
        end else if (bus.s1_ready) begin
            exp_q.push_back({des_ref(d1, key_cur), 1'b1});
            acc_ch.push_back(1);
            acc_cyc.push_back(cyc_n);
            seq++;
        end
        if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 64'(bus.m_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("m_data", bus.m_data, e[64:1]);
                chk("m_id", 64'(bus.m_id), 64'(e[0]));
            end
            pop_cyc.push_back(cyc_n);
        end
        @(posedge clk);
        #2;
        cyc_n++;
    endtask

    task automatic load_key(input logic [55:0] k, input int exp_wait);
        int w;
        w = 0;
        bus.s0_valid  = 1'b0;
        bus.s1_valid  = 1'b0;
        bus.key_valid = 1'b1;
        bus.key_data  = k;
        while (!bus.key_ready && w < 100) begin
            @(posedge clk);
            #2;
            w++;
            cyc_n++;
        end
        chk("key_wait", 64'(w), 64'(exp_wait));
        @(posedge clk);
        #2;
        cyc_n++;
        bus.key_valid = 1'b0;
        #1;
        chk("key_pulse", 64'(bus.key_ready), 64'd0);
        chk("dp_key", 64'(dp_key), 64'(k));
        key_cur = k;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((busy || exp_q.size() != 0) && g < 100) begin
            cyc(1'b0, 1'b0, 1'b1);
            g++;
        end
        chk("drain_busy", 64'(busy), 64'd0);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base, pbase, e0, g, L, f;
        rst = 1'b1;
        bus.s0_valid = 1'b0; bus.s1_valid = 1'b0;
        bus.s0_data  = '0;   bus.s1_data  = '0;
        bus.key_valid = 1'b0; bus.key_data = '0;
        bus.m_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_data", bus.m_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_key_ready", 64'(bus.key_ready), 64'd0);
        chk("rst_dp_key", 64'(dp_key), 64'd0);
        chk("rst_dp_in", {dp_in_l, dp_in_r}, 64'd0);
        rst = 1'b0;

        // No key loaded yet: requests must be refused.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("nokey_ready", 64'(bus.s0_ready), 64'd0);
        chk("nokey_accepts", 64'(acc_ch.size()), 64'd0);
        load_key(56'h0, 1);
        load_key(K1, 2);

        // Single block on ch0: latency and reference value.
        cyc(1'b1, 1'b0, 1'b0);
        chk("single_acc", 64'(acc_ch.size()), 64'd1);
        e0 = acc_cyc[0];
        chk("single_busy", 64'(busy), 64'd1);
        g = 0;
        while (!bus.m_valid && g < 40) begin
            cyc(1'b0, 1'b0, 1'b0);
            g++;
        end
        chk("latency", 64'(cyc_n - 1 - e0), 64'd17);
        chk("single_id", 64'(bus.m_id), 64'd0);
        chk("single_data", bus.m_data, des_ref(64'h0123456789ABCDEF, K1));
        cyc(1'b0, 1'b0, 1'b1);
        chk("single_popped", 64'(bus.m_valid), 64'd0);
        chk("single_idle", 64'(busy), 64'd0);

        // Lone ch1 request is granted and hands the pointer back to ch0.
        cyc(1'b0, 1'b1, 1'b1);
        chk("ch1_acc", 64'(acc_ch[1]), 64'd1);
        drain();

        // Both channels continuously valid, consumer always ready.
        base = acc_ch.size();
        pbase = pop_cyc.size();
        g = 0;
        while (acc_ch.size() < base + 8 && g < 200) begin
            cyc(1'b1, 1'b1, 1'b1);
            g++;
        end
        drain();
        chk("rr_count", 64'(acc_ch.size() - base), 64'd8);
        chk("rr_pops", 64'(pop_cyc.size() - pbase), 64'd8);
        if (acc_ch.size() >= base + 8 && pop_cyc.size() >= pbase + 4) begin
            for (int i = 0; i < 8; i++) chk("rr_order", 64'(acc_ch[base+i]), 64'(i % 2));
            chk("rr_burst", 64'(acc_cyc[base+3] - acc_cyc[base]), 64'd3);
            chk("credit_gap", 64'(acc_cyc[base+4] - acc_cyc[base]), 64'd19);
            chk("first_pop", 64'(pop_cyc[pbase] - acc_cyc[base]), 64'd18);
            chk("pop_run", 64'(pop_cyc[pbase+3] - pop_cyc[pbase]), 64'd3);
        end

        // Backpressure: credit stops admission at FIFO_DEPTH.
        base = acc_ch.size();
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("bp_accepts", 64'(acc_ch.size() - base), 64'(FIFO_DEPTH));
        chk("bp_m_valid", 64'(bus.m_valid), 64'd1);
        chk("bp_ready", 64'(bus.s0_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        pbase = pop_cyc.size();
        drain();
        chk("bp_pops", 64'(pop_cyc.size() - pbase), 64'(FIFO_DEPTH));
        if (pop_cyc.size() >= pbase + 4)
            chk("bp_pop_run", 64'(pop_cyc[pbase+3] - pop_cyc[pbase]), 64'd3);

        // Key change with blocks in flight.
        base = acc_ch.size();
        g = 0;
        while (acc_ch.size() < base + 4 && g < 50) begin
            cyc(1'b1, 1'b0, 1'b1);
            g++;
        end
        L = acc_cyc[acc_cyc.size()-1];
        bus.key_valid = 1'b1;
        bus.key_data  = K2;
        g = 0;
        while (!bus.key_ready && g < 60) begin
            cyc(1'b1, 1'b0, 1'b1);
            g++;
        end
        chk("drain_no_acc", 64'(acc_ch.size() - base), 64'd4);
        chk("drain_wait", 64'(cyc_n - L), 64'd19);
        chk("drain_results", 64'(exp_q.size()), 64'd0);
        chk("drain_idle", 64'(busy), 64'd0);
        cyc(1'b1, 1'b0, 1'b1);
        bus.key_valid = 1'b0;
        key_cur = K2;
        #1;
        chk("new_key", 64'(dp_key), 64'(K2));
        chk("new_key_pulse", 64'(bus.key_ready), 64'd0);
        g = 0;
        while (acc_ch.size() < base + 6 && g < 50) begin
            cyc(1'b1, 1'b0, 1'b1);
            g++;
        end
        drain();

        // Reset with two blocks in flight and two in the FIFO.
        base = acc_ch.size();
        g = 0;
        while (acc_ch.size() < base + 4 && g < 50) begin
            cyc(1'b1, 1'b0, 1'b0);
            g++;
        end
        f = acc_cyc[base];
        g = 0;
        while (cyc_n < f + 19 && g < 40) begin
            cyc(1'b0, 1'b0, 1'b0);
            g++;
        end
        chk("pre_rst_m_valid", 64'(bus.m_valid), 64'd1);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_dp_key", 64'(dp_key), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #2;
        cyc_n++;
        rst = 1'b0;
        base = acc_ch.size();
        for (int i = 0; i < 30; i++) cyc(1'b1, 1'b0, 1'b1);
        chk("post_rst_nokey", 64'(acc_ch.size() - base), 64'd0);
        chk("post_rst_m_valid", 64'(bus.m_valid), 64'd0);
        load_key(K1, 1);
        cyc(1'b0, 1'b1, 1'b1);
        drain();
        chk("recover_acc", 64'(acc_ch.size() - base), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
